// File: rtl/down_timer.sv
// Loadable down-counting interval timer with terminal-count pulse and optional
// auto-reload; all registers update on the falling edge of clk.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | q holds, en ignored; waits for a nonzero load
// RUN   | counter active; decrements on each enabled edge toward terminal
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             tc_r, tc_n;
    logic             terminal;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= ZERO;
            reload <= ZERO;
            tc_r   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            reload <= reload_n;
            tc_r   <= tc_n;
        end
    end

    assign terminal = (state == RUN) && en && (cnt == ONE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        reload_n = reload;
        tc_n     = 1'b0;
        if (load) begin
            cnt_n    = din;
            reload_n = din;
            state_n  = (din != ZERO) ? RUN : IDLE;
        end else if (terminal) begin
            tc_n = 1'b1;
            if (auto_reload) begin
                cnt_n = reload;
            end else begin
                cnt_n   = ZERO;
                state_n = IDLE;
            end
        end else if (state == RUN && en) begin
            // cnt of zero in RUN is unreachable; fall back to IDLE rather than wrap
            if (cnt > ONE) begin
                cnt_n = cnt - ONE;
            end else begin
                state_n = IDLE;
            end
        end
    end

    assign q    = cnt;
    assign tc   = tc_r;
    assign busy = (state == RUN);

endmodule
